// File: rtl/vgroup_writeback_pkg.sv
// Shared constants and helpers for the vector register-group writeback stage.
// Encodings match the vtype decoder.
package vgroup_writeback_pkg;

   localparam int VLEN   = 128;
   localparam int NREG   = 32;
   localparam int VBYTES = VLEN / 8;
   localparam int RIDX_W = 5;

   localparam logic [2:0] SEW_8  = 3'b000;
   localparam logic [2:0] SEW_16 = 3'b001;
   localparam logic [2:0] SEW_32 = 3'b010;

   localparam logic [2:0] LMUL_1 = 3'b000;
   localparam logic [2:0] LMUL_2 = 3'b001;
   localparam logic [2:0] LMUL_4 = 3'b010;
   localparam logic [2:0] LMUL_8 = 3'b011;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GROUP = 1'b1
   } wb_state_e;

   // Elements per register; 0 for an illegal SEW so nothing is ever active.
   function automatic logic [4:0] epr_of(input logic [2:0] sew_enc);
      case (sew_enc)
         SEW_8:   epr_of = 5'd16;
         SEW_16:  epr_of = 5'd8;
         SEW_32:  epr_of = 5'd4;
         default: epr_of = 5'd0;
      endcase
   endfunction

   function automatic logic [2:0] lmul_last(input logic [2:0] lmul_enc);
      case (lmul_enc)
         LMUL_1:  lmul_last = 3'd0;
         LMUL_2:  lmul_last = 3'd1;
         LMUL_4:  lmul_last = 3'd3;
         LMUL_8:  lmul_last = 3'd7;
         default: lmul_last = 3'd0;
      endcase
   endfunction

   function automatic logic cfg_legal(input logic [2:0] sew_enc, input logic [2:0] lmul_enc);
      cfg_legal = (sew_enc <= SEW_32) && (lmul_enc <= LMUL_8);
   endfunction

endpackage

// File: rtl/vgroup_writeback_mask_gen.sv
// Byte mask for one chunk of a register group: bytes below active*bpe take new data.
// Purely combinational.
module vwb_mask_gen
   import vgroup_writeback_pkg::*;
(
   input  logic [2:0]        sew_enc,
   input  logic [8:0]        vl,
   input  logic [2:0]        idx,
   output logic [VBYTES-1:0] byte_mask,
   output logic              none_active
);

   logic signed [9:0] epr_s;
   logic signed [9:0] idx_s;
   logic signed [9:0] rem;
   logic [4:0]        active;
   logic [4:0]        nbytes;

   always_comb begin
      epr_s  = signed'({5'd0, epr_of(sew_enc)});
      idx_s  = signed'({7'd0, idx});
      rem    = signed'({1'b0, vl}) - idx_s * epr_s;
      active = 5'd0;
      if (rem <= 10'sd0)
         active = 5'd0;
      else if (rem > epr_s)
         active = epr_of(sew_enc);
      else
         active = rem[4:0];

      case (sew_enc)
         SEW_8:   nbytes = active;
         SEW_16:  nbytes = {active[3:0], 1'b0};
         SEW_32:  nbytes = {active[2:0], 2'b00};
         default: nbytes = 5'd0;
      endcase

      byte_mask = '0;
      for (int b = 0; b < VBYTES; b++)
         byte_mask[b] = (5'(b) < nbytes);
      none_active = (active == 5'd0);
   end

endmodule

// File: rtl/vgroup_writeback.sv
// Vector writeback stage: merges ALU chunks of an LMUL register group with old
// destination data under a vl/SEW tail mask and drives the register-file write port.
module vgroup_writeback
   import vgroup_writeback_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [VLEN-1:0]    in_data,
   input  logic [RIDX_W-1:0]  in_wa,
   input  logic [2:0]         in_sew_enc,
   input  logic [2:0]         in_lmul_enc,
   input  logic [8:0]         in_vl,
   input  logic               wb_stall,
   output logic [RIDX_W-1:0]  rd_addr,
   input  logic [VLEN-1:0]    rd_data,
   output logic               wen,
   output logic [RIDX_W-1:0]  wa,
   output logic [VLEN-1:0]    wd,
   output logic               group_done,
   output logic               cfg_err
);

   // state    | meaning
   // ST_IDLE  | expecting chunk 0 of a group (idx = 0); config taken from inputs
   // ST_GROUP | chunks 1..LMUL-1 of a group; config taken from latched copy

   wb_state_e         state;
   logic [2:0]        idx;
   logic [RIDX_W-1:0] base_wa;
   logic [2:0]        sew_q;
   logic [2:0]        lmul_q;
   logic [8:0]        vl_q;

   logic              in_idle;
   logic              fire;
   logic              cfg_ok;
   logic              last;
   logic [2:0]        cur_sew;
   logic [2:0]        cur_lmul;
   logic [8:0]        cur_vl;
   logic [2:0]        cur_idx;
   logic [VBYTES-1:0] byte_mask;
   logic              none_active;
   logic              do_write;
   logic [VLEN-1:0]   old_data;
   logic [VLEN-1:0]   merged;

   assign in_ready = !wb_stall;
   assign fire     = in_valid && in_ready;
   assign in_idle  = (state == ST_IDLE);
   assign cur_sew  = in_idle ? in_sew_enc  : sew_q;
   assign cur_lmul = in_idle ? in_lmul_enc : lmul_q;
   assign cur_vl   = in_idle ? in_vl       : vl_q;
   assign cur_idx  = in_idle ? 3'd0        : idx;
   assign rd_addr  = in_idle ? in_wa       : base_wa + {2'b00, idx};
   assign cfg_ok   = !in_idle || cfg_legal(in_sew_enc, in_lmul_enc);
   assign last     = (cur_idx == lmul_last(cur_lmul));
   assign do_write = cfg_ok && !none_active;

   vwb_mask_gen u_mask_gen (
      .sew_enc     (cur_sew),
      .vl          (cur_vl),
      .idx         (cur_idx),
      .byte_mask   (byte_mask),
      .none_active (none_active)
   );

   // The pending write has not reached the register file yet, so it shadows rd_data.
   assign old_data = (wen && (wa == rd_addr)) ? wd : rd_data;

   always_comb begin
      merged = old_data;
      for (int b = 0; b < VBYTES; b++)
         if (byte_mask[b])
            merged[b*8 +: 8] = in_data[b*8 +: 8];
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state      <= ST_IDLE;
         idx        <= 3'd0;
         base_wa    <= '0;
         sew_q      <= 3'd0;
         lmul_q     <= 3'd0;
         vl_q       <= 9'd0;
         wen        <= 1'b0;
         wa         <= '0;
         wd         <= '0;
         group_done <= 1'b0;
         cfg_err    <= 1'b0;
      end else if (fire) begin
         wen        <= do_write;
         group_done <= cfg_ok && last;
         cfg_err    <= !cfg_ok;
         if (do_write) begin
            wa <= rd_addr;
            wd <= merged;
         end
         if (in_idle) begin
            base_wa <= in_wa;
            sew_q   <= in_sew_enc;
            lmul_q  <= in_lmul_enc;
            vl_q    <= in_vl;
            if (cfg_ok && !last) begin
               state <= ST_GROUP;
               idx   <= 3'd1;
            end
         end else if (last) begin
            state <= ST_IDLE;
            idx   <= 3'd0;
         end else begin
            idx <= idx + 3'd1;
         end
      end else if (!wb_stall) begin
         wen        <= 1'b0;
         group_done <= 1'b0;
         cfg_err    <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vgroup_writeback.sv
// Self-checking bench for vgroup_writeback: directed scenarios plus randomized
// traffic against an architectural register-file model.
module tb_vgroup_writeback;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [127:0] in_data = '0;
   logic [4:0]   in_wa = '0;
   logic [2:0]   in_sew_enc = '0;
   logic [2:0]   in_lmul_enc = '0;
   logic [8:0]   in_vl = '0;
   logic         wb_stall = 1'b0;
   logic [4:0]   rd_addr;
   logic [127:0] rd_data;
   logic         wen;
   logic [4:0]   wa;
   logic [127:0] wd;
   logic         group_done;
   logic         cfg_err;

   int errors = 0;
   int checks = 0;

   // Architectural register file as seen by the model (writes take effect at accept).
   logic [127:0] model_rf [32];
   // Physical register file behind the DUT: commits only when a write leaves the port.
   logic [127:0] phys_rf [32];
   logic         load_rf = 1'b0;

   // Model state
   int           m_pos = 0;
   int           m_sew = 0;
   int           m_lmul = 1;
   int           m_vl = 0;
   int           m_base = 0;
   logic         exp_wen = 0, exp_done = 0, exp_err = 0;
   logic [4:0]   exp_wa = '0;
   logic [127:0] exp_wd = '0;

   always #5 clk = ~clk;

   vgroup_writeback dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_data     (in_data),
      .in_wa       (in_wa),
      .in_sew_enc  (in_sew_enc),
      .in_lmul_enc (in_lmul_enc),
      .in_vl       (in_vl),
      .wb_stall    (wb_stall),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .wen         (wen),
      .wa          (wa),
      .wd          (wd),
      .group_done  (group_done),
      .cfg_err     (cfg_err)
   );

   assign rd_data = phys_rf[rd_addr];

   always @(posedge clk) begin
      if (load_rf) begin
         for (int i = 0; i < 32; i++) phys_rf[i] <= model_rf[i];
      end else if (wen === 1'b1 && wb_stall === 1'b0) begin
         phys_rf[wa] <= wd;
      end
   end

   function automatic logic [127:0] rand128();
      return {$urandom(), $urandom(), $urandom(), $urandom()};
   endfunction

   // Reference behaviour for one clock edge, from the architectural rules.
   task automatic model_step();
      int epr, bpe, act, nb, addr;
      logic [127:0] w;
      if (wb_stall) return;
      if (!in_valid) begin
         exp_wen = 0; exp_done = 0; exp_err = 0;
         return;
      end
      if (m_pos == 0) begin
         if (in_sew_enc > 3'd2 || in_lmul_enc > 3'd3) begin
            exp_wen = 0; exp_done = 0; exp_err = 1;
            return;
         end
         m_sew  = int'(in_sew_enc);
         m_lmul = 1 << in_lmul_enc;
         m_vl   = int'(in_vl);
         m_base = int'(in_wa);
      end
      epr  = 16 >> m_sew;
      bpe  = 1 << m_sew;
      act  = m_vl - m_pos * epr;
      if (act < 0) act = 0;
      if (act > epr) act = epr;
      addr = (m_base + m_pos) % 32;
      exp_err  = 0;
      exp_done = (m_pos == m_lmul - 1);
      exp_wen  = (act > 0);
      if (act > 0) begin
         nb = act * bpe;
         w  = model_rf[addr];
         for (int b = 0; b < nb; b++) w[b*8 +: 8] = in_data[b*8 +: 8];
         model_rf[addr] = w;
         exp_wa = 5'(addr);
         exp_wd = w;
      end
      m_pos++;
      if (m_pos == m_lmul) m_pos = 0;
   endtask

   task automatic cycle(input logic v, input logic [127:0] d, input logic [4:0] a,
                        input logic [2:0] s, input logic [2:0] l, input logic [8:0] n,
                        input logic st);
      in_valid = v; in_data = d; in_wa = a; in_sew_enc = s;
      in_lmul_enc = l; in_vl = n; wb_stall = st;
      @(posedge clk); #1;
      model_step();
   endtask

   task automatic do_reset();
      rst = 1'b0; in_valid = 1'b1; wb_stall = 1'b0; load_rf = 1'b1;
      @(posedge clk); #1;
      rst = 1'b1; load_rf = 1'b0; in_valid = 1'b0;
      m_pos = 0;
      exp_wen = 0; exp_done = 0; exp_err = 0; exp_wa = '0; exp_wd = '0;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 32; i++) model_rf[i] = rand128();
      do_reset();
      checks++; if (wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got %0b want 0", wen); end
      checks++; if (wa !== 5'd0) begin errors++; $display("FAIL reset_wa: got %0d want 0", wa); end
      checks++; if (wd !== 128'd0) begin errors++; $display("FAIL reset_wd: got %h want 0", wd); end
      checks++; if (group_done !== 1'b0) begin errors++; $display("FAIL reset_done: got %0b want 0", group_done); end
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b want 0", cfg_err); end
      checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b want 1", in_ready); end
   endtask

   task automatic test_basic();
      model_rf[5] = '1;
      do_reset();
      cycle(1, '0, 5'd5, 3'd2, 3'd0, 9'd3, 0);
      checks++; if (wen !== 1'b1) begin errors++; $display("FAIL basic_wen: got %0b want 1", wen); end
      checks++; if (wa !== 5'd5) begin errors++; $display("FAIL basic_wa: got %0d want 5", wa); end
      checks++; if (wd !== 128'hFFFFFFFF_00000000_00000000_00000000) begin
         errors++; $display("FAIL basic_wd: got %h want ffffffff000000000000000000000000", wd); end
      checks++; if (group_done !== 1'b1) begin errors++; $display("FAIL basic_done: got %0b want 1", group_done); end
      cycle(0, '0, 5'd0, 3'd0, 3'd0, 9'd0, 0);
      checks++; if (wen !== 1'b0 || group_done !== 1'b0) begin
         errors++; $display("FAIL basic_idle: got wen=%0b done=%0b want 0 0", wen, group_done); end
   endtask

   task automatic test_lmul4();
      logic [127:0] d;
      logic [127:0] old10;
      logic [4:0]   want_wa [3] = '{5'd8, 5'd9, 5'd10};
      old10 = model_rf[10];
      for (int c = 0; c < 4; c++) begin
         d = rand128();
         // Chunks after the first carry junk config that must be ignored.
         if (c == 0) cycle(1, d, 5'd8, 3'd0, 3'd2, 9'd40, 0);
         else        cycle(1, d, 5'($urandom), 3'($urandom), 3'($urandom), 9'($urandom), 0);
         checks++; if (wen !== exp_wen) begin errors++; $display("FAIL lmul4_wen%0d: got %0b want %0b", c, wen, exp_wen); end
         checks++; if (group_done !== (c == 3)) begin errors++; $display("FAIL lmul4_done%0d: got %0b want %0b", c, group_done, c == 3); end
         if (c < 3) begin
            checks++; if (wa !== want_wa[c]) begin errors++; $display("FAIL lmul4_wa%0d: got %0d want %0d", c, wa, want_wa[c]); end
            checks++; if (wd !== exp_wd) begin errors++; $display("FAIL lmul4_wd%0d: got %h want %h", c, wd, exp_wd); end
         end
         if (c == 2) begin
            checks++; if (wd !== {old10[127:64], d[63:0]}) begin
               errors++; $display("FAIL lmul4_half: got %h want %h", wd, {old10[127:64], d[63:0]}); end
         end
         if (c == 3) begin
            checks++; if (wen !== 1'b0) begin errors++; $display("FAIL lmul4_nowrite: got %0b want 0", wen); end
         end
      end
   endtask

   task automatic test_wrap();
      logic [4:0] want [4] = '{5'd30, 5'd31, 5'd0, 5'd1};
      for (int c = 0; c < 4; c++) begin
         cycle(1, rand128(), (c == 0) ? 5'd30 : 5'd17, 3'd0, 3'd2, 9'd100, 0);
         checks++; if (wen !== 1'b1 || wa !== want[c]) begin
            errors++; $display("FAIL wrap_wa%0d: got wen=%0b wa=%0d want 1 %0d", c, wen, wa, want[c]); end
         checks++; if (wd !== exp_wd) begin errors++; $display("FAIL wrap_wd%0d: got %h want %h", c, wd, exp_wd); end
      end
   endtask

   task automatic test_bypass();
      logic [127:0] da, db;
      da = rand128(); db = rand128();
      cycle(1, da, 5'd3, 3'd0, 3'd0, 9'd16, 0);
      checks++; if (wd !== da || wa !== 5'd3) begin errors++; $display("FAIL byp_first: got %h want %h", wd, da); end
      cycle(1, db, 5'd3, 3'd0, 3'd0, 9'd1, 0);
      checks++; if (wd !== {da[127:8], db[7:0]}) begin
         errors++; $display("FAIL byp_merge: got %h want %h", wd, {da[127:8], db[7:0]}); end
      checks++; if (wen !== 1'b1 || wa !== 5'd3) begin errors++; $display("FAIL byp_wa: got wen=%0b wa=%0d want 1 3", wen, wa); end
   endtask

   task automatic test_stall();
      for (int c = 0; c < 8; c++) begin
         cycle(1, rand128(), (c == 0) ? 5'd16 : 5'd2, 3'd1, 3'd3, 9'd64, 0);
         checks++; if (wen !== 1'b1 || wa !== 5'(16 + c)) begin
            errors++; $display("FAIL stall_wa%0d: got wen=%0b wa=%0d want 1 %0d", c, wen, wa, 16 + c); end
         checks++; if (wd !== exp_wd) begin errors++; $display("FAIL stall_wd%0d: got %h want %h", c, wd, exp_wd); end
         if (c == 1) begin
            for (int s = 0; s < 3; s++) begin
               cycle(1, rand128(), 5'd9, 3'd0, 3'd0, 9'd5, 1);
               checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL stall_ready%0d: got %0b want 0", s, in_ready); end
               checks++; if (wen !== 1'b1 || wa !== 5'd17 || wd !== exp_wd) begin
                  errors++; $display("FAIL stall_hold%0d: got wen=%0b wa=%0d wd=%h want 1 17 %h", s, wen, wa, wd, exp_wd); end
            end
         end
      end
      checks++; if (group_done !== 1'b1) begin errors++; $display("FAIL stall_done: got %0b want 1", group_done); end
   endtask

   task automatic test_illegal();
      cycle(1, rand128(), 5'd7, 3'd3, 3'd0, 9'd10, 0);
      checks++; if (cfg_err !== 1'b1 || wen !== 1'b0 || group_done !== 1'b0) begin
         errors++; $display("FAIL illegal_sew: got err=%0b wen=%0b done=%0b want 1 0 0", cfg_err, wen, group_done); end
      cycle(1, rand128(), 5'd7, 3'd0, 3'd4, 9'd10, 0);
      checks++; if (cfg_err !== 1'b1 || wen !== 1'b0) begin
         errors++; $display("FAIL illegal_lmul: got err=%0b wen=%0b want 1 0", cfg_err, wen); end
      cycle(0, '0, 5'd0, 3'd0, 3'd0, 9'd0, 0);
      checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL illegal_pulse: got %0b want 0", cfg_err); end
      cycle(1, rand128(), 5'd7, 3'd2, 3'd0, 9'd4, 0);
      checks++; if (wen !== 1'b1 || wa !== 5'd7 || group_done !== 1'b1 || wd !== exp_wd) begin
         errors++; $display("FAIL illegal_after: got wen=%0b wa=%0d done=%0b wd=%h want 1 7 1 %h", wen, wa, group_done, wd, exp_wd); end
   endtask

   task automatic test_reset_mid();
      for (int c = 0; c < 3; c++)
         cycle(1, rand128(), (c == 0) ? 5'd20 : 5'd0, 3'd0, 3'd3, 9'd128, 0);
      do_reset();
      checks++; if (wen !== 1'b0 || group_done !== 1'b0 || wa !== 5'd0 || wd !== 128'd0) begin
         errors++; $display("FAIL rstmid_out: got wen=%0b done=%0b wa=%0d want 0 0 0", wen, group_done, wa); end
      cycle(1, rand128(), 5'd9, 3'd0, 3'd0, 9'd16, 0);
      checks++; if (wen !== 1'b1 || wa !== 5'd9 || group_done !== 1'b1 || wd !== exp_wd) begin
         errors++; $display("FAIL rstmid_chunk0: got wen=%0b wa=%0d done=%0b want 1 9 1", wen, wa, group_done); end
   endtask

   task automatic test_random();
      logic [2:0] s, l;
      for (int i = 0; i < 600; i++) begin
         s = ($urandom_range(19) == 0) ? 3'd3 : 3'($urandom_range(2));
         l = ($urandom_range(19) == 0) ? 3'($urandom_range(7, 4)) : 3'($urandom_range(3));
         cycle($urandom_range(9) < 8, rand128(), 5'($urandom), s, l,
               9'($urandom_range(300)), $urandom_range(9) < 2);
         checks++; if (in_ready !== !wb_stall) begin errors++; $display("FAIL rnd_ready%0d: got %0b want %0b", i, in_ready, !wb_stall); end
         checks++; if (wen !== exp_wen || group_done !== exp_done || cfg_err !== exp_err) begin
            errors++; $display("FAIL rnd_ctl%0d: got wen=%0b done=%0b err=%0b want %0b %0b %0b",
                               i, wen, group_done, cfg_err, exp_wen, exp_done, exp_err); end
         if (exp_wen) begin
            checks++; if (wa !== exp_wa || wd !== exp_wd) begin
               errors++; $display("FAIL rnd_data%0d: got wa=%0d wd=%h want %0d %h", i, wa, wd, exp_wa, exp_wd); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_lmul4();
      test_wrap();
      test_bypass();
      test_stall();
      test_illegal();
      test_reset_mid();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/vgroup_writeback.md
# vgroup_writeback

Vector writeback stage that sits directly downstream of the vALU execute stage and upstream of the vRegFile write port. It accepts one 128-bit ALU result chunk per destination register of an LMUL register group and tracks the chunk index within the group. For each chunk it builds a vl/SEW byte mask and merges the result with the old destination contents, so tail elements stay undisturbed. It then drives the register-file write port one cycle later, with a read-after-write bypass against its own pending write.

## Interface
- VLEN, 128: vector register width in bits; bytes per register = VLEN/8.
- NREG, 32: number of architectural vector registers; register index width = 5.

- clk  input  1  clock
- rst  input  1  reset, synchronous, active-low
- in_valid  input  1  ALU chunk valid
- in_ready  output  1  block can accept a chunk this cycle
- in_data  input  128  ALU result chunk
- in_wa  input  5  base destination register of the group; sampled on chunk 0 only
- in_sew_enc  input  3  000=8, 001=16, 010=32; sampled on chunk 0
- in_lmul_enc  input  3  000=1, 001=2, 010=4, 011=8; sampled on chunk 0
- in_vl  input  9  vector length in elements; sampled on chunk 0
- wb_stall  input  1  register-file write port unavailable
- rd_addr  output  5  old-destination read address (combinational)
- rd_data  input  128  old-destination data (combinational read)
- wen  output  1  register-file write enable
- wa  output  5  register-file write address
- wd  output  128  register-file write data
- group_done  output  1  one-cycle pulse with the write of the last chunk of a group
- cfg_err  output  1  one-cycle pulse on accepting a chunk 0 that has an illegal SEW/LMUL encoding

## Operation
- A handshake completes when in_valid and in_ready are both high. in_ready equals !wb_stall.
- FSM states:
  - IDLE, with idx=0.
  - GROUP, with idx in 1..LMUL-1.
- Chunk 0 accepted in IDLE:
  - Latch base_wa, sew, lmul and vl.
  - If LMUL>1, move to GROUP.
- Each accepted chunk in GROUP increments idx. When idx reaches LMUL-1 and that chunk is accepted, return to IDLE.
- Derived values:
  - epr = VLEN/SEW, giving 16, 8 or 4 elements per register.
  - bpe = SEW/8 bytes per element.
  - active = clamp(vl − idx·epr, 0, epr), computed in 10-bit signed arithmetic.
  - vl > VLMAX therefore clamps naturally.
- Byte mask: byte b takes in_data when b < active·bpe. Otherwise it takes the old data.
- Destination register = (base_wa + idx) mod 32. For chunk 0 it is in_wa directly. rd_addr presents this same address.
- Old-data bypass: if the output register holds a valid write (wen=1) whose wa equals the current rd_addr, use wd instead of rd_data.
- active = 0 (including vl = 0): the chunk is consumed and the index advances, but no write is issued (wen = 0).
- Illegal encoding (sew_enc > 2 or lmul_enc > 3, fractional LMUL unsupported):
  - The chunk is consumed and cfg_err pulses.
  - No write is issued and the FSM stays in IDLE.
- group_done pulses even when the final chunk's write is suppressed.

## Timing
- Latency: a chunk accepted at edge t appears as wen/wa/wd in the cycle after edge t. There is exactly one output register stage.
- Throughput: one chunk per cycle when wb_stall = 0.
- wb_stall = 1:
  - in_ready = 0.
  - The output register and FSM hold, and wen/wa/wd stay stable.
  - wen remains asserted if it was asserted; the register file must not commit while stalled.
- Back-to-back groups: chunk 0 of the next group may be accepted in the same cycle the previous group's last write is presented.
- Reset (rst = 0 at an edge):
  - FSM returns to IDLE with idx = 0.
  - wen = 0, wa = 0, wd = 0, group_done = 0, cfg_err = 0, and the latched config is 0.
  - Reset mid-group discards the partial group; nothing further is written.

## Structure
- A shared package holds:
  - SEW and LMUL encoding constants, identical to vtype_decoder's.
  - VLEN and NREG defaults.
  - A function returning epr from sew_enc.
- One sub-module, vwb_mask_gen, is combinational. It takes sew_enc, vl and idx and produces a 16-bit byte mask plus an active==0 flag.
- The FSM, the bypass logic and the output register live in the top module.

## Test plan
- SEW = 32, LMUL = 1, vl = 3, in_wa = 5, old v5 = all 0xFF, in_data = 0 -> next cycle wen = 1, wa = 5, wd = 0xFFFFFFFF_00000000_00000000_00000000, group_done = 1.
- SEW = 8, LMUL = 4, vl = 40, base 8, four consecutive chunks -> writes to v8 (all 16 bytes new), v9 (16 bytes new), v10 (low 8 bytes new), then no write for v11; group_done on the 4th chunk.
- Base 30, LMUL = 4 -> write addresses 30, 31, 0, 1.
- Bypass: group writing v3, immediately followed by a group whose chunk 0 targets v3 with vl = 1, SEW = 8 -> byte 0 is new, bytes 1..15 equal the previous group's wd, not the stale rd_data.
- wb_stall high for 3 cycles mid-group -> in_ready = 0, wen/wa/wd held constant, idx unchanged; resumes with the correct sequence.
- sew_enc = 3 -> cfg_err pulse, wen = 0. Then rst low mid LMUL = 8 group -> wen = 0 next cycle and the following chunk is treated as chunk 0.
